// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the IFU/LSU AXI4-Lite arbiter.
package axi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IFU  = 2'd1;
  localparam logic [1:0] OWN_LSU  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/arb_pick.sv
// Combinational request-to-owner selection: LSU write first, then reads.
// With ARB_RR_EN the IFU/LSU read tie alternates using the last read owner.
module arb_pick
  import axi_arb_pkg::*;
(
  input  logic       ifu_rd_req,
  input  logic       lsu_rd_req,
  input  logic       lsu_wr_req,
`ifdef ARB_RR_EN
  input  logic [1:0] rr_last,
`endif
  output logic [1:0] pick_owner,
  output logic       pick_write
);

  always_comb begin
    pick_owner = OWN_NONE;
    pick_write = 1'b0;
    if (lsu_wr_req) begin
      pick_owner = OWN_LSU;
      pick_write = 1'b1;
    end else if (lsu_rd_req && ifu_rd_req) begin
`ifdef ARB_RR_EN
      pick_owner = (rr_last == OWN_LSU) ? OWN_IFU : OWN_LSU;
`else
      pick_owner = OWN_LSU;
`endif
    end else if (lsu_rd_req) begin
      pick_owner = OWN_LSU;
    end else if (ifu_rd_req) begin
      pick_owner = OWN_IFU;
    end
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Shares one AXI4-Lite slave between the IFU (read-only) and LSU (read/write),
// one transaction at a time. Optional macro ARB_RR_EN: round-robin read ties.
module axi_lite_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  input  logic                ifu_rready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rvalid,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  input  logic                lsu_rready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rvalid,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_awvalid,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wvalid,
  output logic                lsu_awready,
  output logic                lsu_wready,
  input  logic                lsu_bready,
  output logic [1:0]          lsu_bresp,
  output logic                lsu_bvalid,
  output logic [ADDR_W-1:0]   mem_araddr,
  output logic                mem_arvalid,
  output logic                mem_rready,
  input  logic                mem_arready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic [1:0]          mem_rresp,
  input  logic                mem_rvalid,
  output logic [ADDR_W-1:0]   mem_awaddr,
  output logic                mem_awvalid,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_wvalid,
  output logic                mem_bready,
  input  logic                mem_awready,
  input  logic                mem_wready,
  input  logic [1:0]          mem_bresp,
  input  logic                mem_bvalid,
  output logic [1:0]          gnt
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Only the owner's channel is connected; valid never depends on ready.
  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [1:0]  pick_owner;
  logic        pick_write;
  logic        own_ifu;
  logic        aw_fin, w_fin;

  assign own_ifu = (owner_q == OWN_IFU);
  assign aw_fin  = aw_done_q | (mem_awvalid & mem_awready);
  assign w_fin   = w_done_q | (mem_wvalid & mem_wready);

`ifdef ARB_RR_EN
  logic [1:0]  rr_last_q, rr_last_d;

  arb_pick u_pick (
    .ifu_rd_req (ifu_arvalid),
    .lsu_rd_req (lsu_arvalid),
    .lsu_wr_req (lsu_awvalid | lsu_wvalid),
    .rr_last    (rr_last_q),
    .pick_owner (pick_owner),
    .pick_write (pick_write)
  );
`else
  arb_pick u_pick (
    .ifu_rd_req (ifu_arvalid),
    .lsu_rd_req (lsu_arvalid),
    .lsu_wr_req (lsu_awvalid | lsu_wvalid),
    .pick_owner (pick_owner),
    .pick_write (pick_write)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_NONE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef ARB_RR_EN
      rr_last_q <= OWN_IFU;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifdef ARB_RR_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  // Channel muxing: everything not forwarded in the current state is 0.
  always_comb begin
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bresp   = '0;
    lsu_bvalid  = 1'b0;
    mem_araddr  = '0;
    mem_arvalid = 1'b0;
    mem_rready  = 1'b0;
    mem_awaddr  = '0;
    mem_awvalid = 1'b0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    mem_wvalid  = 1'b0;
    mem_bready  = 1'b0;
    gnt         = owner_q;
    case (state_q)
      ST_RD_ADDR: begin
        mem_araddr  = own_ifu ? ifu_araddr : lsu_araddr;
        mem_arvalid = own_ifu ? ifu_arvalid : lsu_arvalid;
        if (own_ifu) ifu_arready = mem_arready;
        else         lsu_arready = mem_arready;
      end
      ST_RD_DATA: begin
        mem_rready = own_ifu ? ifu_rready : lsu_rready;
        if (own_ifu) begin
          ifu_rdata  = mem_rdata;
          ifu_rresp  = mem_rresp;
          ifu_rvalid = mem_rvalid;
        end else begin
          lsu_rdata  = mem_rdata;
          lsu_rresp  = mem_rresp;
          lsu_rvalid = mem_rvalid;
        end
      end
      ST_WR_REQ: begin
        if (!aw_done_q) begin
          mem_awaddr  = lsu_awaddr;
          mem_awvalid = lsu_awvalid;
          lsu_awready = mem_awready;
        end
        if (!w_done_q) begin
          mem_wdata  = lsu_wdata;
          mem_wstrb  = lsu_wstrb;
          mem_wvalid = lsu_wvalid;
          lsu_wready = mem_wready;
        end
      end
      ST_WR_RESP: begin
        mem_bready = lsu_bready;
        lsu_bresp  = mem_bresp;
        lsu_bvalid = mem_bvalid;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifdef ARB_RR_EN
    rr_last_d = rr_last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_owner != OWN_NONE) begin
          owner_d = pick_owner;
          state_d = pick_write ? ST_WR_REQ : ST_RD_ADDR;
`ifdef ARB_RR_EN
          if (!pick_write) rr_last_d = pick_owner;
`endif
        end
      end
      ST_RD_ADDR: begin
        if (mem_arvalid && mem_arready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (mem_rvalid && mem_rready) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end
      end
      ST_WR_REQ: begin
        // AW and W complete independently; move on once both have landed.
        if (aw_fin && w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_WR_RESP;
        end else begin
          aw_done_d = aw_fin;
          w_done_d  = w_fin;
        end
      end
      ST_WR_RESP: begin
        if (mem_bvalid && mem_bready) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: master driver tasks, a slave model,
// and a response scoreboard popped by an independent monitor.
module tb_axi_lite_arbiter;

  localparam int MAX_WAIT = 200;

  logic        clk, rst;
  logic [31:0] ifu_araddr;  logic ifu_arvalid, ifu_arready, ifu_rready;
  logic [31:0] ifu_rdata;   logic [1:0] ifu_rresp;  logic ifu_rvalid;
  logic [31:0] lsu_araddr;  logic lsu_arvalid, lsu_arready, lsu_rready;
  logic [31:0] lsu_rdata;   logic [1:0] lsu_rresp;  logic lsu_rvalid;
  logic [31:0] lsu_awaddr;  logic lsu_awvalid;
  logic [31:0] lsu_wdata;   logic [3:0] lsu_wstrb;  logic lsu_wvalid;
  logic        lsu_awready, lsu_wready, lsu_bready, lsu_bvalid;
  logic [1:0]  lsu_bresp;
  logic [31:0] mem_araddr;  logic mem_arvalid, mem_rready, mem_arready;
  logic [31:0] mem_rdata;   logic [1:0] mem_rresp;  logic mem_rvalid;
  logic [31:0] mem_awaddr;  logic mem_awvalid;
  logic [31:0] mem_wdata;   logic [3:0] mem_wstrb;  logic mem_wvalid, mem_bready;
  logic        mem_awready, mem_wready, mem_bvalid;
  logic [1:0]  mem_bresp;
  logic [1:0]  gnt;

  axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_awready(lsu_awready),
    .lsu_wready(lsu_wready), .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid),
    .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_rready(mem_rready),
    .mem_arready(mem_arready), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid),
    .mem_awaddr(mem_awaddr), .mem_awvalid(mem_awvalid), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_wvalid(mem_wvalid), .mem_bready(mem_bready),
    .mem_awready(mem_awready), .mem_wready(mem_wready), .mem_bresp(mem_bresp), .mem_bvalid(mem_bvalid),
    .gnt(gnt)
  );

  wire [183:0] all_outs = {gnt, ifu_arready, ifu_rvalid, ifu_rresp, ifu_rdata,
                           lsu_arready, lsu_rvalid, lsu_rresp, lsu_rdata,
                           lsu_awready, lsu_wready, lsu_bvalid, lsu_bresp,
                           mem_araddr, mem_arvalid, mem_rready, mem_awaddr, mem_awvalid,
                           mem_wdata, mem_wstrb, mem_wvalid, mem_bready};

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish before 200000");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [35:0] exp_q[$];  // {src(1=IFU R,2=LSU R,3=LSU B), resp, data}

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got timeout, required DUT handshake within %0d cycles", name, MAX_WAIT);
  endtask

  task automatic sb_pop(input string name, input logic [35:0] act);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got unexpected response %0h, required none", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (ifu_rvalid && ifu_rready) sb_pop("ifu_r", {2'd1, ifu_rresp, ifu_rdata});
      if (lsu_rvalid && lsu_rready) sb_pop("lsu_r", {2'd2, lsu_rresp, lsu_rdata});
      if (lsu_bvalid && lsu_bready) sb_pop("lsu_b", {2'd3, lsu_bresp, 32'd0});
    end
  end

  // ---------------- slave model ----------------
  int ar_delay_cfg = 0, r_delay_cfg = 2, aw_delay_cfg = 0, w_delay_cfg = 0;
  logic [1:0] rresp_cfg = 2'b00, bresp_cfg = 2'b00;
  logic n_arvalid, n_ar_fire, n_r_fire, n_awvalid, n_aw_fire, n_wvalid, n_w_fire, n_b_fire;
  logic [31:0] n_araddr, cap_awaddr, cap_wdata;
  logic [3:0] cap_wstrb;
  int aw_hs_cnt = 0, w_hs_cnt = 0;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return ~a;
  endfunction

  initial begin
    {n_arvalid, n_ar_fire, n_r_fire, n_awvalid, n_aw_fire, n_wvalid, n_w_fire, n_b_fire} = '0;
    n_araddr = '0; cap_awaddr = '0; cap_wdata = '0; cap_wstrb = '0;
    forever begin
      @(negedge clk);
      n_arvalid = mem_arvalid;
      n_ar_fire = mem_arvalid && mem_arready;
      n_araddr  = mem_araddr;
      n_r_fire  = mem_rvalid && mem_rready;
      n_awvalid = mem_awvalid;
      n_aw_fire = mem_awvalid && mem_awready;
      n_wvalid  = mem_wvalid;
      n_w_fire  = mem_wvalid && mem_wready;
      n_b_fire  = mem_bvalid && mem_bready;
      if (n_aw_fire) begin aw_hs_cnt++; cap_awaddr = mem_awaddr; end
      if (n_w_fire) begin w_hs_cnt++; cap_wdata = mem_wdata; cap_wstrb = mem_wstrb; end
    end
  end

  initial begin
    int rd_st, ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic [31:0] rd_addr;
    logic aw_got, w_got;
    rd_st = 0; ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    rd_addr = '0; aw_got = 1'b0; w_got = 1'b0;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = '0;
    mem_awready = 1'b0; mem_wready = 1'b0; mem_bvalid = 1'b0; mem_bresp = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        rd_st = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        aw_got = 1'b0; w_got = 1'b0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = '0;
        mem_awready = 1'b0; mem_wready = 1'b0; mem_bvalid = 1'b0; mem_bresp = '0;
      end else begin
        case (rd_st)
          0: if (n_ar_fire) begin
               mem_arready = 1'b0; rd_addr = n_araddr; r_cnt = r_delay_cfg; ar_cnt = 0; rd_st = 1;
             end else if (n_arvalid && !mem_arready) begin
               if (ar_cnt >= ar_delay_cfg) mem_arready = 1'b1;
               else ar_cnt++;
             end
          1: if (r_cnt == 0) begin
               mem_rvalid = 1'b1; mem_rdata = rd_model(rd_addr); mem_rresp = rresp_cfg; rd_st = 2;
             end else r_cnt--;
          default: if (n_r_fire) begin
               mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = '0; rd_st = 0;
             end
        endcase
        if (n_aw_fire) begin
          mem_awready = 1'b0; aw_got = 1'b1; aw_cnt = 0;
        end else if (n_awvalid && !mem_awready) begin
          if (aw_cnt >= aw_delay_cfg) mem_awready = 1'b1;
          else aw_cnt++;
        end
        if (n_w_fire) begin
          mem_wready = 1'b0; w_got = 1'b1; w_cnt = 0;
        end else if (n_wvalid && !mem_wready) begin
          if (w_cnt >= w_delay_cfg) mem_wready = 1'b1;
          else w_cnt++;
        end
        if (n_b_fire) begin
          mem_bvalid = 1'b0; mem_bresp = '0; aw_got = 1'b0; w_got = 1'b0;
        end else if (aw_got && w_got && !mem_bvalid) begin
          if (b_cnt >= 1) begin mem_bvalid = 1'b1; mem_bresp = bresp_cfg; b_cnt = 0; end
          else b_cnt++;
        end
      end
    end
  end

  // ---------------- master driver tasks ----------------
  task automatic ifu_read(input logic [31:0] addr);
    int n; logic fired;
    ifu_araddr = addr; ifu_arvalid = 1'b1;
    n = 0; fired = 1'b0;
    while (!fired && n < MAX_WAIT) begin
      @(negedge clk); n++;
      if (ifu_arvalid && ifu_arready) fired = 1'b1;
    end
    if (!fired) fail_timeout("ifu_ar_wait");
    @(posedge clk); #1;
    ifu_arvalid = 1'b0; ifu_araddr = '0;
    n = 0; fired = 1'b0;
    while (!fired && n < MAX_WAIT) begin
      @(negedge clk); n++;
      if (ifu_rvalid && ifu_rready) fired = 1'b1;
    end
    if (!fired) fail_timeout("ifu_r_wait");
    @(posedge clk); #1;
  endtask

  task automatic lsu_read(input logic [31:0] addr);
    int n; logic fired;
    lsu_araddr = addr; lsu_arvalid = 1'b1;
    n = 0; fired = 1'b0;
    while (!fired && n < MAX_WAIT) begin
      @(negedge clk); n++;
      if (lsu_arvalid && lsu_arready) fired = 1'b1;
    end
    if (!fired) fail_timeout("lsu_ar_wait");
    @(posedge clk); #1;
    lsu_arvalid = 1'b0; lsu_araddr = '0;
    n = 0; fired = 1'b0;
    while (!fired && n < MAX_WAIT) begin
      @(negedge clk); n++;
      if (lsu_rvalid && lsu_rready) fired = 1'b1;
    end
    if (!fired) fail_timeout("lsu_r_wait");
    @(posedge clk); #1;
  endtask

  task automatic lsu_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n; logic aw_ok, w_ok, a_f, w_f, fired;
    lsu_awaddr = addr; lsu_awvalid = 1'b1;
    lsu_wdata = data; lsu_wstrb = strb; lsu_wvalid = 1'b1;
    n = 0; aw_ok = 1'b0; w_ok = 1'b0;
    while (!(aw_ok && w_ok) && n < MAX_WAIT) begin
      @(negedge clk); n++;
      a_f = lsu_awvalid && lsu_awready;
      w_f = lsu_wvalid && lsu_wready;
      @(posedge clk); #1;
      if (a_f) begin lsu_awvalid = 1'b0; lsu_awaddr = '0; aw_ok = 1'b1; end
      if (w_f) begin lsu_wvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0; w_ok = 1'b1; end
    end
    if (!(aw_ok && w_ok)) fail_timeout("lsu_aw_w_wait");
    n = 0; fired = 1'b0;
    while (!fired && n < MAX_WAIT) begin
      @(negedge clk); n++;
      if (lsu_bvalid && lsu_bready) fired = 1'b1;
    end
    if (!fired) fail_timeout("lsu_b_wait");
    @(posedge clk); #1;
  endtask

  // ---------------- directed tests ----------------
  int          aw_d_tab[4] = '{0, 2, 0, 0};
  int          w_d_tab[4]  = '{2, 0, 0, 0};
  logic [1:0]  br_tab[4]   = '{2'b00, 2'b00, 2'b00, 2'b10};

  initial begin
    int n; logic seen, bad;
    rst = 1'b0;
    ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_rready = 1'b1;
    lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rready = 1'b1;
    lsu_awaddr = '0; lsu_awvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 1'b0;
    lsu_bready = 1'b1;
    #3 rst = 1'b1;
    #1 check("reset_all_outputs", all_outs, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // IFU-only read with one-cycle arbitration latency
    exp_q.push_back({2'd1, 2'b00, 32'h0000_0413});
    fork
      ifu_read(32'h8000_0000);
      begin
        @(negedge clk); check("gnt_idle_latency", gnt, 2'd0);
        @(negedge clk); check("gnt_ifu_granted", gnt, 2'd1);
      end
    join
    @(negedge clk); check("gnt_back_idle", gnt, 2'd0);
    @(posedge clk); #1;

    // Read tie, then the LSU re-requests so a second tie occurs
`ifdef ARB_RR_EN
    exp_q.push_back({2'd2, 2'b00, 32'h7fff_efff});
    exp_q.push_back({2'd1, 2'b00, 32'h7fff_ffef});
    exp_q.push_back({2'd2, 2'b00, 32'h7fff_effb});
`else
    exp_q.push_back({2'd2, 2'b00, 32'h7fff_efff});
    exp_q.push_back({2'd2, 2'b00, 32'h7fff_effb});
    exp_q.push_back({2'd1, 2'b00, 32'h7fff_ffef});
`endif
    fork
      ifu_read(32'h8000_0010);
      begin lsu_read(32'h8000_1000); lsu_read(32'h8000_1004); end
      begin
        @(negedge clk); @(negedge clk); check("gnt_first_tie_lsu", gnt, 2'd2);
      end
    join
    @(posedge clk); #1;

    // LSU write: AW first, W first, same cycle, and a SLVERR B response
    for (int v = 0; v < 4; v++) begin
      aw_delay_cfg = aw_d_tab[v]; w_delay_cfg = w_d_tab[v]; bresp_cfg = br_tab[v];
      aw_hs_cnt = 0; w_hs_cnt = 0;
      exp_q.push_back({2'd3, br_tab[v], 32'd0});
      lsu_write(32'ha000_03f8, 32'h0000_0041, 4'b0001);
      check($sformatf("wr%0d_aw_count", v), aw_hs_cnt, 1);
      check($sformatf("wr%0d_w_count", v), w_hs_cnt, 1);
      check($sformatf("wr%0d_awaddr", v), cap_awaddr, 32'ha000_03f8);
      check($sformatf("wr%0d_wdata", v), cap_wdata, 32'h0000_0041);
      check($sformatf("wr%0d_wstrb", v), cap_wstrb, 4'b0001);
      @(posedge clk); #1;
    end
    aw_delay_cfg = 1; w_delay_cfg = 0; bresp_cfg = 2'b00;

    // IFU read pending while an LSU write owns the port
    exp_q.push_back({2'd3, 2'b00, 32'd0});
    exp_q.push_back({2'd1, 2'b00, 32'h7fff_ffdf});
    fork
      lsu_write(32'ha000_03f8, 32'h0000_0041, 4'b0001);
      ifu_read(32'h8000_0020);
      begin
        n = 0; seen = 1'b0; bad = 1'b0;
        while (!seen && n < MAX_WAIT) begin
          @(negedge clk); n++;
          if (ifu_arready) bad = 1'b1;
          if (lsu_bvalid && lsu_bready) seen = 1'b1;
        end
        if (!seen) fail_timeout("wr_block_b_wait");
        check("ifu_arready_during_write", bad, 1'b0);
        @(negedge clk); check("gnt_idle_after_b", gnt, 2'd0);
        @(negedge clk); check("gnt_ifu_after_b", gnt, 2'd1);
      end
    join
    @(posedge clk); #1;

    // SLVERR read responses pass through unchanged
    rresp_cfg = 2'b10;
    exp_q.push_back({2'd2, 2'b10, 32'h7fff_dfff});
    lsu_read(32'h8000_2000);
    exp_q.push_back({2'd1, 2'b10, 32'h7fff_ffbf});
    ifu_read(32'h8000_0040);
    rresp_cfg = 2'b00;
    @(posedge clk); #1;

    // Reset while the read response is stalled in RD_DATA
    ifu_rready = 1'b0;
    ifu_araddr = 32'h8000_0030; ifu_arvalid = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < MAX_WAIT) begin
      @(negedge clk); n++;
      if (ifu_arvalid && ifu_arready) seen = 1'b1;
    end
    if (!seen) fail_timeout("rst_test_ar_wait");
    @(posedge clk); #1;
    ifu_arvalid = 1'b0; ifu_araddr = '0;
    n = 0; seen = 1'b0;
    while (!seen && n < MAX_WAIT) begin
      @(negedge clk); n++;
      if (ifu_rvalid) seen = 1'b1;
    end
    check("pre_rst_ifu_rvalid", ifu_rvalid, 1'b1);
    check("pre_rst_gnt", gnt, 2'd1);
    #2 rst = 1'b1;
    #1 check("mid_rst_all_outputs", all_outs, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; ifu_rready = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back({2'd1, 2'b00, 32'h0000_0413});
    ifu_read(32'h8000_0000);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
